snake_score_counter: RTL
========================

Name: snake_score_counter

Overview:
- Producer end of the score_h/score_l BCD interface that WATCH consumes.
- Converts "food eaten" events from the game core into a saturating two-digit BCD score, gated by the run enable (CLR) and the end-of-game indication.
- Emits a one-cycle strobe whenever the displayed score changes.
- Sits between SNAKE_GAME and WATCH at the snake_game_box level.

Parameters:
- POINTS, 1, BCD points added per eat event; legal range 1..9.
- EAT_EDGE, 1, 1 = count rising edges of eat; 0 = count every cycle eat is high (bench/debug use only).

Ports:
- CLK1_50  input  1  system clock, 50 MHz.
- RESET  input  1  synchronous, active-high reset.
- CLR  input  1  run enable; 1 = game running, counting permitted.
- eat  input  1  food-eaten level/pulse from game core.
- game_over  input  1  end-of-game indication from game core.
- HI_CLR  input  1  synchronous clear of the high score (used only with the optional feature).
- score_h  output  4  BCD tens digit.
- score_l  output  4  BCD units digit.
- inc  output  1  one-cycle strobe; score changed this cycle.
- sat  output  1  score saturated at 99.
- stop  output  1  high while in OVER.
- hi_h  output  4  high score, tens digit.
- hi_l  output  4  high score, units digit.
- new_record  output  1  last finished game beat the stored high score.

Behaviour:
- All registers are updated on the rising edge of CLK1_50. RESET is synchronous, active-high, and has priority over every other input.
- RESET values: score_h=0, score_l=0, inc=0, sat=0, stop=0, new_record=0, state=IDLE. eat_d is loaded with the current eat value, so an eat held high through reset is not counted.
- hi_h/hi_l are not cleared by RESET. They are cleared by HI_CLR, and have power-up init value 00.
- State machine, encoded in 2 bits:
  - IDLE: score held. Go to RUN when CLR=1.
  - RUN: counting. Go to OVER when game_over=1 or CLR=0.
  - OVER: score frozen, stop=1. Leave only via RESET.
  - The fourth encoding returns to IDLE.
- Eat event in RUN:
  - With EAT_EDGE=1: eat=1 and eat_d=0 at the sampling edge.
  - With EAT_EDGE=0: eat=1.
  - Score and inc update on that same edge, so outputs change with zero extra cycles of latency. inc is high for exactly one cycle.
- BCD add:
  - u = score_l + POINTS (5-bit).
  - If u > 9: score_l = u - 10 and carry = 1; else score_l = u and carry = 0.
  - t = score_h + carry. If t > 9, score forces to 9/9 and sat = 1.
- Saturation: once sat=1, further eats leave the score at 99 and keep inc=0. sat clears only on RESET.
- Events outside RUN (IDLE or OVER) are ignored, and inc=0.
- Simultaneous eat event and game_over/CLR=0 in RUN: the eat is counted on that edge and the state moves to OVER on the same edge.
- Simultaneous HI_CLR and an OVER transition: HI_CLR wins, and the high score ends at 00.
- score_h and score_l are never non-BCD (never >9) at any time.

Optional Feature:
- Macro: SNAKE_SCORE_HISCORE_EN.
- With the macro defined:
  - On the edge that enters OVER, compare {score_h,score_l} with {hi_h,hi_l} as an unsigned 8-bit BCD value.
  - If the score is strictly greater, load the high score from the score and set new_record=1. Otherwise new_record=0.
  - new_record holds until RESET.
- Without the macro: hi_h=0, hi_l=0, new_record=0 constantly, and HI_CLR is ignored. The ports remain present.

Test Plan:
- Counting from reset: RESET, CLR=1, 12 single-cycle eat pulses with POINTS=1 -> score_h=1, score_l=2, exactly 12 inc strobes, sat=0.
- Carry and saturation: POINTS=7, CLR=1, 15 eat edges -> 07, 14, 21, ... 98 after the 14th; the 15th gives 99 with sat=1 and an inc strobe; a 16th edge leaves 99 with inc=0.
- Level eat: eat held high for 20 cycles with EAT_EDGE=1 -> score +1 only. RESET while eat=1, then CLR=1 with eat still high -> score 00, no count.
- End of game: score 05, eat edge on the same cycle as game_over=1 -> score 06, stop=1 next cycle; later eat edges do not change the score; CLR toggling does not leave OVER; RESET returns to 00 and stop=0.
- High score, macro on: game ends at 23 -> hi=23, new_record=1. RESET; next game ends at 17 -> hi=23, new_record=0. HI_CLR -> hi=00.
- Gating: with CLR=0 from reset, 5 eat edges -> score 00, inc never asserted, state stays IDLE.

Source files
------------

// File: rtl/snake_score_if.sv
// -----------------------------------------------------------------------------
// snake_score_if
// Signal bundle between the game core (SNAKE_GAME), the score counter and the
// display (WATCH).
//   master : the score counter side. It receives the game-core controls and
//            drives the score/high-score outputs.
//   slave  : the game-core/display side. It drives the controls and receives
//            the score.
// Signals:
//   CLR        run enable, 1 = game running
//   eat        food-eaten level/pulse
//   game_over  end-of-game indication
//   HI_CLR     synchronous clear of the stored high score
//   score_h/l  BCD score digits (tens/units)
//   inc        one-cycle strobe, score changed
//   sat        score saturated at 99
//   stop       game is in its OVER state
//   hi_h/l     BCD high-score digits
//   new_record last finished game beat the stored high score
// -----------------------------------------------------------------------------
interface snake_score_if;
    logic       CLR;
    logic       eat;
    logic       game_over;
    logic       HI_CLR;
    logic [3:0] score_h;
    logic [3:0] score_l;
    logic       inc;
    logic       sat;
    logic       stop;
    logic [3:0] hi_h;
    logic [3:0] hi_l;
    logic       new_record;

    modport master (
        input  CLR, eat, game_over, HI_CLR,
        output score_h, score_l, inc, sat, stop, hi_h, hi_l, new_record
    );

    modport slave (
        output CLR, eat, game_over, HI_CLR,
        input  score_h, score_l, inc, sat, stop, hi_h, hi_l, new_record
    );
endinterface

// File: rtl/snake_score_counter.sv
// -----------------------------------------------------------------------------
// snake_score_counter
// Turns food-eaten events from the game core into a saturating two-digit BCD
// score for the WATCH display. Counting only happens while the game runs
// (CLR=1, state RUN); the score freezes once the game ends (OVER) and only
// RESET starts a new game.
//
// Parameters:
//   POINTS   BCD points added per eat event, 1..9
//   EAT_EDGE 1 = count rising edges of eat, 0 = count every cycle eat is high
//
// Ports:
//   CLK1_50  system clock (50 MHz), all registers on its rising edge
//   RESET    synchronous active-high reset, priority over every other input
//   bus      snake_score_if.master: CLR, eat, game_over, HI_CLR in;
//            score_h, score_l, inc, sat, stop, hi_h, hi_l, new_record out
//
// Optional feature: define SNAKE_SCORE_HISCORE_EN to keep a high score that is
// updated on the edge entering OVER. Without it hi_h/hi_l/new_record are
// constant zero and HI_CLR is ignored.
// -----------------------------------------------------------------------------
module snake_score_counter #(
    parameter int unsigned POINTS   = 1,
    parameter bit          EAT_EDGE = 1'b1
) (
    input  logic           CLK1_50,
    input  logic           RESET,
    snake_score_if.master  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [3:0] score_h_reg;
    logic [3:0] score_h_next;
    logic [3:0] score_l_reg;
    logic [3:0] score_l_next;
    logic       inc_reg;
    logic       inc_next;
    logic       sat_reg;
    logic       sat_next;
    logic       eat_d_reg;

    logic       eat_hit;
    logic       eat_event;
    logic       ending;
    logic [4:0] units_sum;
    logic [3:0] units_wrap;
    logic       carry;
    logic [3:0] tens_sum;

    // Edge mode ignores an eat that was already high on the previous edge,
    // including one held high through RESET (eat_d is loaded during reset).
    assign eat_hit   = EAT_EDGE ? (bus.eat & ~eat_d_reg) : bus.eat;
    assign eat_event = (state_reg == ST_RUN) && eat_hit;
    assign ending    = (state_reg == ST_RUN) && (bus.game_over || !bus.CLR);

    // BCD add of one digit plus carry into the tens digit. The wrapped units
    // value is only used when the sum exceeds 9, so 4-bit modular arithmetic
    // gives the exact digit (0..8).
    assign units_sum  = {1'b0, score_l_reg} + 5'(POINTS);
    assign carry      = (units_sum > 5'd9);
    assign units_wrap = score_l_reg + 4'(POINTS) - 4'd10;
    assign tens_sum   = score_h_reg + {3'd0, carry};

    always_comb begin
        score_h_next = score_h_reg;
        score_l_next = score_l_reg;
        sat_next     = sat_reg;
        inc_next     = 1'b0;
        if (eat_event && !sat_reg) begin
            if (tens_sum > 4'd9) begin
                // Overflow past 99 pins the score; inc only if it moved.
                score_h_next = 4'd9;
                score_l_next = 4'd9;
                sat_next     = 1'b1;
                inc_next     = (score_h_reg != 4'd9) || (score_l_reg != 4'd9);
            end else begin
                score_h_next = tens_sum;
                score_l_next = carry ? units_wrap : units_sum[3:0];
                inc_next     = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.CLR) state_next = ST_RUN;
            ST_RUN:  if (ending)  state_next = ST_OVER;
            ST_OVER: state_next = ST_OVER;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK1_50) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            score_h_reg <= 4'd0;
            score_l_reg <= 4'd0;
            inc_reg     <= 1'b0;
            sat_reg     <= 1'b0;
            eat_d_reg   <= bus.eat;
        end else begin
            state_reg   <= state_next;
            score_h_reg <= score_h_next;
            score_l_reg <= score_l_next;
            inc_reg     <= inc_next;
            sat_reg     <= sat_next;
            eat_d_reg   <= bus.eat;
        end
    end

    assign bus.score_h = score_h_reg;
    assign bus.score_l = score_l_reg;
    assign bus.inc     = inc_reg;
    assign bus.sat     = sat_reg;
    assign bus.stop    = (state_reg == ST_OVER);

`ifdef SNAKE_SCORE_HISCORE_EN
    // High score survives RESET; it powers up as 00 and only HI_CLR clears it.
    logic [3:0] hi_h_reg = 4'd0;
    logic [3:0] hi_l_reg = 4'd0;
    logic       new_record_reg;
    logic       beats_hi;

    // The final score of the game is the one written on the ending edge, so
    // an eat counted on that same edge takes part in the comparison. BCD
    // digits order the same way as the decimal value.
    assign beats_hi = {score_h_next, score_l_next} > {hi_h_reg, hi_l_reg};

    always_ff @(posedge CLK1_50) begin
        if (RESET) begin
            new_record_reg <= 1'b0;
        end else begin
            if (ending) begin
                new_record_reg <= beats_hi;
            end
            if (bus.HI_CLR) begin
                hi_h_reg <= 4'd0;
                hi_l_reg <= 4'd0;
            end else if (ending && beats_hi) begin
                hi_h_reg <= score_h_next;
                hi_l_reg <= score_l_next;
            end
        end
    end

    assign bus.hi_h       = hi_h_reg;
    assign bus.hi_l       = hi_l_reg;
    assign bus.new_record = new_record_reg;
`else
    logic unused_hi_clr;
    assign unused_hi_clr  = bus.HI_CLR;
    assign bus.hi_h       = 4'd0;
    assign bus.hi_l       = 4'd0;
    assign bus.new_record = 1'b0;
`endif

endmodule
